// File: rtl/match_controller_pkg.sv
// match_controller_pkg: state encoding, winner codes and score helper shared by the match controller
package match_controller_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_MATCH_END = 3'd4
    } state_t;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction
endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: game-rate inputs and fight/display outputs of the match controller
interface match_controller_if;
    logic       tick;
    logic       start;
    logic       gameOver1;
    logic       gameOver2;
    logic [1:0] hp1;
    logic [1:0] hp2;
    logic       logic_en;
    logic       logic_reset;
    logic [1:0] countdown;
    logic [1:0] wins1;
    logic [1:0] wins2;
    logic [1:0] round_winner;
    logic       match_over;
    logic [2:0] state;
    modport master (
        output tick, start, gameOver1, gameOver2, hp1, hp2,
        input  logic_en, logic_reset, countdown, wins1, wins2, round_winner, match_over, state
    );
    modport slave (
        input  tick, start, gameOver1, gameOver2, hp1, hp2,
        output logic_en, logic_reset, countdown, wins1, wins2, round_winner, match_over, state
    );
endinterface

// File: rtl/match_controller_tick_counter.sv
// match_controller_tick_counter: tick-enabled modulo-MOD counter with clear and terminal-count flag
module match_controller_tick_counter #(
    parameter int MOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [W-1:0] LAST = W'(MOD - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc = (cnt_q == LAST);
    always_comb cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/match_controller.sv
// match_controller: best-of-N match sequencer (countdown, fight, round end, match end) gating the fight logic
module match_controller
    import match_controller_pkg::*;
#(
    parameter int COUNT_START = 3,
    parameter int COUNT_TICKS = 4,
    parameter int ROUND_TICKS = 60,
    parameter int PAUSE_TICKS = 8,
    parameter int WINS_NEEDED = 2
) (
    input logic clk,
    input logic reset,
    match_controller_if.slave bus
);
    localparam logic [1:0] CS = 2'(COUNT_START);
    localparam logic [1:0] WN = 2'(WINS_NEEDED);
    state_t     state_q, state_d;
    logic [1:0] cd_q, cd_d, w1_q, w1_d, w2_q, w2_d, rw_q, rw_d, win;
    logic       en_q, en_d, lr_q, lr_d, mo_q, mo_d;
    logic       cd_tc, rt_tc, pt_tc, clr;
    // every state change restarts all tick timers from zero
    assign clr = (state_d != state_q);
    match_controller_tick_counter #(.MOD(COUNT_TICKS)) u_cd (
        .clk(clk), .reset(reset), .en(bus.tick && state_q == ST_COUNTDOWN), .clr(clr), .tc(cd_tc));
    match_controller_tick_counter #(.MOD(ROUND_TICKS)) u_rt (
        .clk(clk), .reset(reset), .en(bus.tick && state_q == ST_FIGHT), .clr(clr), .tc(rt_tc));
    match_controller_tick_counter #(.MOD(PAUSE_TICKS)) u_pt (
        .clk(clk), .reset(reset), .en(bus.tick && state_q == ST_ROUND_END), .clr(clr), .tc(pt_tc));
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        rw_d    = rw_q;
        win     = (bus.gameOver1 && bus.gameOver2) ? WIN_NONE :
                  bus.gameOver1 ? WIN_P2 : bus.gameOver2 ? WIN_P1 :
                  (bus.hp1 > bus.hp2) ? WIN_P1 : (bus.hp2 > bus.hp1) ? WIN_P2 : WIN_NONE;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d = ST_COUNTDOWN;
                cd_d    = CS;
                w1_d    = '0;
                w2_d    = '0;
                rw_d    = WIN_NONE;
            end
            ST_COUNTDOWN: if (bus.tick && cd_tc) begin
                cd_d = cd_q - 2'd1;
                if (cd_q == 2'd1) state_d = ST_FIGHT;
            end
            ST_FIGHT: if (bus.tick && (bus.gameOver1 || bus.gameOver2 || rt_tc)) begin
                state_d = ST_ROUND_END;
                rw_d    = win;
                w1_d    = (win == WIN_P1) ? sat_inc(w1_q) : w1_q;
                w2_d    = (win == WIN_P2) ? sat_inc(w2_q) : w2_q;
            end
            ST_ROUND_END: if (bus.tick && pt_tc) begin
                if (w1_q >= WN || w2_q >= WN) state_d = ST_MATCH_END;
                else begin
                    state_d = ST_COUNTDOWN;
                    cd_d    = CS;
                    rw_d    = WIN_NONE;
                end
            end
            ST_MATCH_END: if (bus.tick && bus.start) begin
                state_d = ST_COUNTDOWN;
                cd_d    = CS;
                w1_d    = '0;
                w2_d    = '0;
                rw_d    = WIN_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
        en_d = (state_d == ST_FIGHT);
        lr_d = (state_d == ST_IDLE) || (state_d == ST_COUNTDOWN);
        mo_d = (state_d == ST_MATCH_END);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            rw_q    <= WIN_NONE;
            en_q    <= 1'b0;
            lr_q    <= 1'b1;
            mo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            rw_q    <= rw_d;
            en_q    <= en_d;
            lr_q    <= lr_d;
            mo_q    <= mo_d;
        end
    end
    assign bus.logic_en     = en_q;
    assign bus.logic_reset  = lr_q;
    assign bus.countdown    = cd_q;
    assign bus.wins1        = w1_q;
    assign bus.wins2        = w2_q;
    assign bus.round_winner = rw_q;
    assign bus.match_over   = mo_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed and randomized checks of match_controller against a phase-level match model
module tb_match_controller;
    localparam int CS = 3, CT = 4, RT = 5, PT = 8, WN = 2;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    match_controller_if bus();
    match_controller #(
        .COUNT_START(CS), .COUNT_TICKS(CT), .ROUND_TICKS(RT), .PAUSE_TICKS(PT), .WINS_NEEDED(WN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: phase 0..4, digit shown, ticks left in digit/pause, fight ticks elapsed, score, last winner
    typedef struct {int ph; int cd; int left; int el; int w1; int w2; int rw;} mdl_t;
    mdl_t m;

    function automatic mdl_t next_m(mdl_t s);
        mdl_t n = s;
        int win = -1;
        if (s.ph == 0 && bus.start) begin
            n.ph = 1; n.cd = CS; n.left = CT; n.w1 = 0; n.w2 = 0; n.rw = 0;
        end else if (bus.tick) begin
            if (s.ph == 1) begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.cd = s.cd - 1;
                    n.left = CT;
                    if (n.cd == 0) begin n.ph = 2; n.el = 0; end
                end
            end else if (s.ph == 2) begin
                n.el = s.el + 1;
                if (bus.gameOver1 && bus.gameOver2) win = 0;
                else if (bus.gameOver1) win = 2;
                else if (bus.gameOver2) win = 1;
                else if (n.el == RT) win = (bus.hp1 > bus.hp2) ? 1 : (bus.hp2 > bus.hp1) ? 2 : 0;
                if (win >= 0) begin
                    n.ph = 3; n.rw = win; n.left = PT;
                    if (win == 1) n.w1 = (s.w1 < 3) ? s.w1 + 1 : 3;
                    if (win == 2) n.w2 = (s.w2 < 3) ? s.w2 + 1 : 3;
                end
            end else if (s.ph == 3) begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    if (s.w1 >= WN || s.w2 >= WN) n.ph = 4;
                    else begin n.ph = 1; n.cd = CS; n.left = CT; n.rw = 0; end
                end
            end else if (s.ph == 4 && bus.start) begin
                n.ph = 1; n.cd = CS; n.left = CT; n.w1 = 0; n.w2 = 0; n.rw = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) m <= reset ? '{default: 0} : next_m(m);

    always @(negedge clk) if (!reset) begin
        chk("state", int'(bus.state), m.ph);
        chk("logic_en", int'(bus.logic_en), int'(m.ph == 2));
        chk("logic_reset", int'(bus.logic_reset), int'(m.ph <= 1));
        chk("countdown", int'(bus.countdown), m.cd);
        chk("wins1", int'(bus.wins1), m.w1);
        chk("wins2", int'(bus.wins2), m.w2);
        chk("round_winner", int'(bus.round_winner), m.rw);
        chk("match_over", int'(bus.match_over), int'(m.ph == 4));
    end

    task automatic cyc(input logic tk, input logic st, input logic g1 = 1'b0, input logic g2 = 1'b0);
        bus.tick = tk; bus.start = st; bus.gameOver1 = g1; bus.gameOver2 = g2;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0);
    endtask

    task automatic to_fight();
        ticks(CT * CS);
        chk("fight_entry", int'(bus.state), 2);
    endtask

    initial begin
        bus.tick = 0; bus.start = 0; bus.gameOver1 = 0; bus.gameOver2 = 0; bus.hp1 = 3; bus.hp2 = 3;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_lreset", int'(bus.logic_reset), 1);
        chk("rst_len", int'(bus.logic_en), 0);
        chk("rst_cd", int'(bus.countdown), 0);
        chk("rst_mo", int'(bus.match_over), 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        chk("idle_hold", int'(bus.state), 0);
        cyc(1'b1, 1'b1);
        chk("cd_start", int'(bus.countdown), 3);
        for (int i = 1; i < 12; i++) begin
            cyc(1'b1, 1'b0);
            chk("cd_digit", int'(bus.countdown), 3 - i / 4);
            chk("cd_len", int'(bus.logic_en), 0);
        end
        cyc(1'b1, 1'b0);
        chk("fight_len", int'(bus.logic_en), 1);
        chk("fight_lreset", int'(bus.logic_reset), 0);
        chk("fight_cd", int'(bus.countdown), 0);
        bus.hp1 = 2; bus.hp2 = 1;
        repeat (4) begin cyc(1'b1, 1'b0); chk("timeout_wait", int'(bus.state), 2); end
        cyc(1'b1, 1'b0);
        chk("timeout_rw", int'(bus.round_winner), 1);
        chk("timeout_w1", int'(bus.wins1), 1);
        chk("timeout_state", int'(bus.state), 3);
        repeat (7) begin cyc(1'b1, 1'b0); chk("pause_wait", int'(bus.state), 3); end
        cyc(1'b1, 1'b0);
        chk("pause_state", int'(bus.state), 1);
        chk("pause_cd", int'(bus.countdown), 3);
        chk("pause_rw", int'(bus.round_winner), 0);
        to_fight();
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("dko_rw", int'(bus.round_winner), 0);
        chk("dko_w1", int'(bus.wins1), 1);
        chk("dko_w2", int'(bus.wins2), 0);
        ticks(PT);
        bus.hp1 = 3; bus.hp2 = 3;
        to_fight();
        ticks(RT);
        chk("draw_state", int'(bus.state), 3);
        chk("draw_rw", int'(bus.round_winner), 0);
        ticks(PT);
        to_fight();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("p2_rw", int'(bus.round_winner), 2);
        chk("p2_w2", int'(bus.wins2), 1);
        ticks(PT);
        to_fight();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        ticks(PT);
        chk("me_state", int'(bus.state), 4);
        chk("me_over", int'(bus.match_over), 1);
        chk("me_rw", int'(bus.round_winner), 2);
        chk("me_w2", int'(bus.wins2), 2);
        repeat (3) begin cyc(1'b0, 1'b1); chk("me_notick", int'(bus.state), 4); end
        cyc(1'b1, 1'b0);
        chk("me_nostart", int'(bus.state), 4);
        cyc(1'b1, 1'b1);
        chk("rematch_state", int'(bus.state), 1);
        chk("rematch_w1", int'(bus.wins1), 0);
        chk("rematch_w2", int'(bus.wins2), 0);
        repeat (CT * CS) cyc(1'b1, 1'b1);
        chk("start_ignored", int'(bus.state), 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(PT);
        to_fight();
        ticks(2);
        #2 reset = 1'b1;
        #1;
        chk("arst_len", int'(bus.logic_en), 0);
        chk("arst_lreset", int'(bus.logic_reset), 1);
        chk("arst_state", int'(bus.state), 0);
        chk("arst_w1", int'(bus.wins1), 0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            bus.hp1 = 2'($urandom_range(0, 3));
            bus.hp2 = 2'($urandom_range(0, 3));
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
            if (i % 731 == 400) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences the fight logic through a best-of-N match: countdown, fight, round end, match end.
- Holds the game logic in reset during countdown and enables it only while fighting.
- Tallies round wins and applies a round time limit.
- Sits in the game top between the game-rate divider output and the fight logic; exposes countdown/score values for the seven-segment driver.

Parameters:
- COUNT_START, 3, first countdown digit shown (counts COUNT_START..1).
- COUNT_TICKS, 4, ticks per countdown digit.
- ROUND_TICKS, 60, fight time limit in ticks.
- PAUSE_TICKS, 8, ticks spent in ROUND_END before next round.
- WINS_NEEDED, 2, round wins that end the match (max 3).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk-wide game-rate strobe from divider
- start  in  1  level; request new match
- gameOver1  in  1  player 1 defeated (hp1 reached 0)
- gameOver2  in  1  player 2 defeated
- hp1  in  2  player 1 hit points
- hp2  in  2  player 2 hit points
- logic_en  out  1  enable to fight logic
- logic_reset  out  1  reset to fight logic
- countdown  out  2  current countdown digit, 0 outside COUNTDOWN
- wins1  out  2  round wins player 1
- wins2  out  2  round wins player 2
- round_winner  out  2  00 none/draw, 01 p1, 10 p2; valid in ROUND_END/MATCH_END
- match_over  out  1  high in MATCH_END
- state  out  3  encoded state for debug/display

Behaviour:
- Reset (async, reset=1):
  - Enter IDLE.
  - logic_en=0, logic_reset=1, countdown=0, wins1=wins2=0, round_winner=00, match_over=0.
  - All tick counters cleared.
- All outputs are registered.
- Only the transition out of IDLE is evaluated every clk. All other transitions and counters advance only on clk edges with tick=1.
- IDLE:
  - logic_reset=1, logic_en=0.
  - start=1 on any clk → COUNTDOWN next cycle; clear wins1/wins2; countdown=COUNT_START.
- COUNTDOWN:
  - logic_reset=1 (level, held for the whole state so the slow-clocked logic sees it), logic_en=0.
  - Tick counter runs 0..COUNT_TICKS-1. On wrap, countdown decrements.
  - On wrap with countdown=1 → FIGHT; countdown=0; round timer cleared.
- FIGHT:
  - logic_reset=0, logic_en=1. Round timer increments per tick.
  - Evaluated per tick, in priority order:
    1. gameOver1 & gameOver2 → draw (no point).
    2. gameOver1 → p2 point.
    3. gameOver2 → p1 point.
    4. Timer = ROUND_TICKS-1 → timeout: higher hp wins; equal hp is a draw.
  - Any of these outcomes → ROUND_END; set round_winner; increment the winner's count, saturating at 3.
  - gameOver inputs are sampled only on tick cycles.
- ROUND_END:
  - logic_en=0, logic_reset=0 (freeze final hp on display).
  - After PAUSE_TICKS ticks:
    - wins1 or wins2 ≥ WINS_NEEDED → MATCH_END.
    - Otherwise → COUNTDOWN, countdown=COUNT_START, round_winner=00.
- MATCH_END:
  - match_over=1, logic_en=0; round_winner holds the match winner.
  - start=1 with tick → COUNTDOWN with wins cleared (rematch).
  - start=0 with tick → stay.
- start is ignored in COUNTDOWN, FIGHT, and ROUND_END.
- Draw rounds do not change the score; the match continues indefinitely on repeated draws.
- state encoding: IDLE=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_END=4. Values 5–7 are illegal and recover to IDLE on the next clk.
- reset asserted mid-round returns to IDLE immediately, regardless of tick.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE..ST_MATCH_END);
  - winner codes (WIN_NONE=00, WIN_P1=01, WIN_P2=10).
- Natural sub-module: tick_counter. A tick-enabled modulo counter with load/clear and terminal-count output, instantiated for the countdown digit, round timer, and pause timer.

Test Plan:
- Async reset pulse mid-FIGHT, no clk edge → logic_en=0, logic_reset=1, state=0, wins cleared immediately.
- Countdown timing, tick every clk, defaults: start → countdown shows 3,2,1 for 4 ticks each; logic_en=1 exactly 12 ticks after leaving IDLE.
- Round outcome: gameOver2=1 on a FIGHT tick → round_winner=01, wins1=1, state=3. After 8 ticks → COUNTDOWN, countdown=3.
- Simultaneous KO: gameOver1=gameOver2=1 on the same tick → round_winner=00, wins unchanged.
- Timeout, ROUND_TICKS=5: hp1=2, hp2=1, no gameOver → after 5 FIGHT ticks round_winner=01. With hp1=hp2=3 → draw.
- Match end and rematch: p2 wins two rounds → match_over=1, round_winner=10, wins2=2. start held in MATCH_END on a tick → COUNTDOWN, wins1=wins2=0.
